// File: rtl/parking_gate_ctrl.sv
// Multi-lane parking gate controller: per-lane a/b direction FSMs feed
// enter/exit/seq_err pulses into a shared saturating occupancy counter.
// Ports: clk, reset (sync, active high); a/b sensors per lane;
// car_enter/car_exit/seq_err pulses per lane; cnt, full, empty, ovf, unf.
module parking_gate_ctrl #(
  parameter int N_LANES  = 2,
  parameter int CNT_W    = 8,
  parameter int CAPACITY = 200
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_LANES-1:0] a,
  input  logic [N_LANES-1:0] b,
  output logic [N_LANES-1:0] car_enter,
  output logic [N_LANES-1:0] car_exit,
  output logic [N_LANES-1:0] seq_err,
  output logic [CNT_W-1:0]   cnt,
  output logic               full,
  output logic               empty,
  output logic               ovf,
  output logic               unf
);

  // Two guard bits: one for headroom above CAPACITY, one as sign.
  localparam int W = CNT_W + $clog2(N_LANES) + 2;
  localparam logic [W-1:0] CAP = W'(CAPACITY);

  typedef enum logic [2:0] {
    IDLE, E1, E2, E3, X1, X2, X3
  } state_t;

  state_t st     [N_LANES];
  state_t st_nxt [N_LANES];

  logic [N_LANES-1:0] enter_d;
  logic [N_LANES-1:0] exit_d;
  logic [N_LANES-1:0] err_d;

  logic [W-1:0] add;
  logic [W-1:0] sub;
  logic [W-1:0] sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_LANES; i++) st[i] <= IDLE;
      car_enter <= '0;
      car_exit  <= '0;
      seq_err   <= '0;
    end else begin
      for (int i = 0; i < N_LANES; i++) st[i] <= st_nxt[i];
      car_enter <= enter_d;
      car_exit  <= exit_d;
      seq_err   <= err_d;
    end
  end

  always_comb begin
    enter_d = '0;
    exit_d  = '0;
    err_d   = '0;
    for (int i = 0; i < N_LANES; i++) begin
      st_nxt[i] = st[i];
      case (st[i])
        IDLE:
          case ({a[i], b[i]})
            2'b10:   st_nxt[i] = E1;
            2'b01:   st_nxt[i] = X1;
            2'b11:   err_d[i] = 1'b1;
            default: st_nxt[i] = IDLE;
          endcase
        E1:
          case ({a[i], b[i]})
            2'b11:   st_nxt[i] = E2;
            2'b10:   st_nxt[i] = E1;
            2'b00:   st_nxt[i] = IDLE;
            default: begin
              st_nxt[i] = IDLE;
              err_d[i]  = 1'b1;
            end
          endcase
        E2:
          case ({a[i], b[i]})
            2'b01:   st_nxt[i] = E3;
            2'b11:   st_nxt[i] = E2;
            2'b10:   st_nxt[i] = E1;
            default: begin
              st_nxt[i] = IDLE;
              err_d[i]  = 1'b1;
            end
          endcase
        E3:
          case ({a[i], b[i]})
            2'b00: begin
              st_nxt[i]  = IDLE;
              enter_d[i] = 1'b1;
            end
            2'b01:   st_nxt[i] = E3;
            2'b11:   st_nxt[i] = E2;
            default: begin
              st_nxt[i] = IDLE;
              err_d[i]  = 1'b1;
            end
          endcase
        X1:
          case ({a[i], b[i]})
            2'b11:   st_nxt[i] = X2;
            2'b01:   st_nxt[i] = X1;
            2'b00:   st_nxt[i] = IDLE;
            default: begin
              st_nxt[i] = IDLE;
              err_d[i]  = 1'b1;
            end
          endcase
        X2:
          case ({a[i], b[i]})
            2'b10:   st_nxt[i] = X3;
            2'b11:   st_nxt[i] = X2;
            2'b01:   st_nxt[i] = X1;
            default: begin
              st_nxt[i] = IDLE;
              err_d[i]  = 1'b1;
            end
          endcase
        X3:
          case ({a[i], b[i]})
            2'b00: begin
              st_nxt[i] = IDLE;
              exit_d[i] = 1'b1;
            end
            2'b10:   st_nxt[i] = X3;
            2'b11:   st_nxt[i] = X2;
            default: begin
              st_nxt[i] = IDLE;
              err_d[i]  = 1'b1;
            end
          endcase
        default: st_nxt[i] = IDLE;
      endcase
    end
  end

  // Enters and exits net out before clamping.
  always_comb begin
    add = '0;
    sub = '0;
    for (int i = 0; i < N_LANES; i++) begin
      add = add + W'(car_enter[i]);
      sub = sub + W'(car_exit[i]);
    end
    sum = W'(cnt) + add - sub;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (sum[W-1]) begin
      cnt <= '0;
      unf <= 1'b1;
    end else if (sum > CAP) begin
      cnt <= CAP[CNT_W-1:0];
      ovf <= 1'b1;
    end else begin
      cnt <= sum[CNT_W-1:0];
    end
  end

  assign full  = (cnt == CAP[CNT_W-1:0]);
  assign empty = (cnt == '0);

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Scoreboard bench for parking_gate_ctrl: path-position lane model and
// integer occupancy model push expected observations; a monitor compares.
module tb_parking_gate_ctrl;

  localparam int CAP = 200;

  typedef struct packed {
    logic [1:0] en;
    logic [1:0] ex;
    logic [1:0] er;
    logic [7:0] cnt;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] a;
  logic [1:0] b;
  logic [1:0] car_enter;
  logic [1:0] car_exit;
  logic [1:0] seq_err;
  logic [7:0] cnt;
  logic       full;
  logic       empty;
  logic       ovf;
  logic       unf;

  parking_gate_ctrl #(
    .N_LANES (2),
    .CNT_W   (8),
    .CAPACITY(CAP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a),
    .b        (b),
    .car_enter(car_enter),
    .car_exit (car_exit),
    .seq_err  (seq_err),
    .cnt      (cnt),
    .full     (full),
    .empty    (empty),
    .ovf      (ovf),
    .unf      (unf)
  );

  always #5 clk = ~clk;

  obs_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Lane model: direction (0 none, 1 entering, 2 exiting) and how far
  // along that direction's sensor path the car is (1..3).
  logic [1:0] ent_path [3];
  logic [1:0] ext_path [3];
  int         dir [2];
  int         pos [2];
  int         mcnt;
  bit         movf;
  bit         munf;
  bit  [1:0]  pe;
  bit  [1:0]  px;

  task automatic lane_model(input int i, input logic [1:0] ab,
                            output bit en, output bit ex, output bit er);
    logic [1:0] p [3];
    en = 0; ex = 0; er = 0;
    if (dir[i] == 0) begin
      if (ab == ent_path[0]) begin dir[i] = 1; pos[i] = 1; end
      else if (ab == ext_path[0]) begin dir[i] = 2; pos[i] = 1; end
      else if (ab == 2'b11) er = 1;
    end else begin
      p = (dir[i] == 1) ? ent_path : ext_path;
      if (ab == p[pos[i]-1]) begin
      end else if (pos[i] < 3 && ab == p[pos[i]]) begin
        pos[i]++;
      end else if (pos[i] > 1 && ab == p[pos[i]-2]) begin
        pos[i]--;
      end else if (ab == 2'b00) begin
        if (pos[i] == 3) begin
          if (dir[i] == 1) en = 1; else ex = 1;
        end else if (pos[i] == 2) begin
          er = 1;
        end
        dir[i] = 0;
      end else begin
        er = 1;
        dir[i] = 0;
      end
    end
  endtask

  task automatic step(input logic [1:0] ab0, input logic [1:0] ab1,
                      input logic r);
    obs_t e;
    int   n;
    bit   en0, ex0, er0, en1, ex1, er1;
    a = {ab1[1], ab0[1]};
    b = {ab1[0], ab0[0]};
    reset = r;
    if (r) begin
      dir[0] = 0; dir[1] = 0;
      mcnt = 0; movf = 0; munf = 0;
      pe = 0; px = 0;
      e.er = 0;
    end else begin
      n = mcnt + $countones(pe) - $countones(px);
      if (n > CAP) begin mcnt = CAP; movf = 1; end
      else if (n < 0) begin mcnt = 0; munf = 1; end
      else mcnt = n;
      lane_model(0, ab0, en0, ex0, er0);
      lane_model(1, ab1, en1, ex1, er1);
      pe = {en1, en0};
      px = {ex1, ex0};
      e.er = {er1, er0};
    end
    e.en    = pe;
    e.ex    = px;
    e.cnt   = 8'(mcnt);
    e.full  = (mcnt == CAP);
    e.empty = (mcnt == 0);
    e.ovf   = movf;
    e.unf   = munf;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // m: 0 idle, 1 enter, 2 exit; four cycles per car.
  task automatic cars(input int m0, input int m1);
    logic [1:0] s0, s1;
    for (int t = 0; t < 4; t++) begin
      s0 = (m0 == 1) ? ((t < 3) ? ent_path[t] : 2'b00)
         : (m0 == 2) ? ((t < 3) ? ext_path[t] : 2'b00) : 2'b00;
      s1 = (m1 == 1) ? ((t < 3) ? ent_path[t] : 2'b00)
         : (m1 == 2) ? ((t < 3) ? ext_path[t] : 2'b00) : 2'b00;
      step(s0, s1, 1'b0);
    end
  endtask

  always @(negedge clk) begin
    obs_t e, g;
    if (q.size() > 0) begin
      e = q.pop_front();
      g = '{car_enter, car_exit, seq_err, cnt, full, empty, ovf, unf};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL obs t=%0t got en=%b ex=%b er=%b cnt=%0d f=%b e=%b o=%b u=%b exp en=%b ex=%b er=%b cnt=%0d f=%b e=%b o=%b u=%b",
                 $time, g.en, g.ex, g.er, g.cnt, g.full, g.empty, g.ovf, g.unf,
                 e.en, e.ex, e.er, e.cnt, e.full, e.empty, e.ovf, e.unf);
      end
    end
  end

  initial begin
    logic [1:0] ab [2];
    ent_path[0] = 2'b10; ent_path[1] = 2'b11; ent_path[2] = 2'b01;
    ext_path[0] = 2'b01; ext_path[1] = 2'b11; ext_path[2] = 2'b10;
    pos[0] = 1; pos[1] = 1;

    step(2'b00, 2'b00, 1'b1);
    step(2'b00, 2'b00, 1'b1);
    step(2'b00, 2'b00, 1'b0);

    cars(1, 0);
    step(2'b00, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b0);

    cars(0, 2);
    step(2'b00, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b0);

    step(2'b10, 2'b00, 1'b0);
    step(2'b11, 2'b00, 1'b0);
    step(2'b10, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b0);

    step(2'b11, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b0);
    step(2'b10, 2'b00, 1'b0);
    step(2'b01, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b0);

    for (int r = 0; r < 100; r++) cars(1, 1);
    step(2'b00, 2'b00, 1'b0);
    cars(1, 0);
    step(2'b00, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b0);
    cars(1, 2);
    step(2'b00, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b0);

    step(2'b00, 2'b00, 1'b1);
    cars(0, 2);
    step(2'b00, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b0);
    step(2'b10, 2'b00, 1'b0);
    step(2'b11, 2'b00, 1'b0);
    step(2'b01, 2'b00, 1'b1);
    step(2'b00, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b0);

    ab[0] = 2'b00;
    ab[1] = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++)
        if ($urandom_range(0, 9) < 3) ab[i] = 2'($urandom_range(0, 3));
      step(ab[0], ab[1], $urandom_range(0, 299) == 0);
    end
    step(2'b00, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b0);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
